// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, flag bit positions and FSM encoding.
// ALU_SEQ_ADC_EN adds the two-pass add-with-carry opcode.
package alu_pkg;

  localparam int NREG   = 4;
  localparam int REG_AW = 2;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOT = 4'd11;
  localparam logic [3:0] ALU_ADC = 4'd12;

  localparam int FLG_C = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_S = 1;
  localparam int FLG_V = 0;

`ifdef ALU_SEQ_ADC_EN
  localparam bit ADC_EN = 1'b1;
`else
  localparam bit ADC_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
`ifdef ALU_SEQ_ADC_EN
    ST_EXEC2 = 2'd2,
`endif
    ST_DONE  = 2'd3
  } seq_state_e;

  function automatic logic op_supported(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOT: return 1'b1;
      ALU_ADC: return ADC_EN;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 4x8 register file: two combinational read ports, one synchronous write port,
// asynchronously cleared to zero.
module alu_regfile
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  output logic [7:0]        rdata1,
  output logic [7:0]        rdata2,
  input  logic              we,
  input  logic [REG_AW-1:0] waddr,
  input  logic [7:0]        wdata
);

  logic [7:0] mem_q [NREG];
  logic [7:0] mem_d [NREG];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: 8'h00};
    else     mem_q <= mem_d;
  end

  assign rdata1 = mem_q[raddr1];
  assign rdata2 = mem_q[raddr2];

endmodule

// File: rtl/alu_sequencer.sv
// Issue/writeback controller around an external combinational 8-bit ALU.
// Define ALU_SEQ_ADC_EN to support op 12 (ADC) as two chained ALU add passes.
module alu_sequencer
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [3:0]  instr_op,
  input  logic [1:0]  instr_rd,
  input  logic [1:0]  instr_rs1,
  input  logic [1:0]  instr_rs2,
  input  logic        instr_use_imm,
  input  logic [7:0]  instr_imm,
  output logic [7:0]  alu_in1,
  output logic [7:0]  alu_in2,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_out,
  input  logic [3:0]  alu_flags,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [7:0]  res_data,
  output logic [3:0]  res_flags,
  output logic        res_err
);

  seq_state_e        state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [7:0]        alu_in1_q, alu_in1_d;
  logic [7:0]        alu_in2_q, alu_in2_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [3:0]        flags_q, flags_d;
  logic              res_valid_q, res_valid_d;
  logic [7:0]        res_data_q, res_data_d;
  logic              res_err_q, res_err_d;
  logic              instr_ready_q, instr_ready_d;
`ifdef ALU_SEQ_ADC_EN
  logic              c1_q, c1_d;
  logic              v1_q, v1_d;
`endif

  logic              rf_we;
  logic [7:0]        rf_rdata1, rf_rdata2;

  alu_regfile u_regfile (
    .clk    (clk),
    .rst    (rst),
    .raddr1 (instr_rs1),
    .raddr2 (instr_rs2),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2),
    .we     (rf_we),
    .waddr  (rd_q),
    .wdata  (alu_out)
  );

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    rd_d          = rd_q;
    alu_in1_d     = alu_in1_q;
    alu_in2_d     = alu_in2_q;
    alu_op_d      = alu_op_q;
    flags_d       = flags_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_err_d     = res_err_q;
    instr_ready_d = instr_ready_q;
    rf_we         = 1'b0;
`ifdef ALU_SEQ_ADC_EN
    c1_d          = c1_q;
    v1_d          = v1_q;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d          = instr_op;
          rd_d          = instr_rd;
          alu_in1_d     = rf_rdata1;
          alu_in2_d     = instr_use_imm ? instr_imm : rf_rdata2;
          alu_op_d      = instr_op;
          if (instr_op == ALU_NOT) alu_in2_d = 8'h00;
`ifdef ALU_SEQ_ADC_EN
          if (instr_op == ALU_ADC) alu_op_d = ALU_ADD;
`endif
          instr_ready_d = 1'b0;
          state_d       = ST_EXEC;
        end
      end

      ST_EXEC: begin
`ifdef ALU_SEQ_ADC_EN
        // ADC pass 1 done: chain its sum into a second add of the pre-instruction carry.
        if (op_q == ALU_ADC) begin
          c1_d      = alu_flags[FLG_C];
          v1_d      = alu_flags[FLG_V];
          alu_in1_d = alu_out;
          alu_in2_d = {7'b0, flags_q[FLG_C]};
          alu_op_d  = ALU_ADD;
          state_d   = ST_EXEC2;
        end else
`endif
        begin
          if (op_supported(op_q)) begin
            rf_we          = 1'b1;
            flags_d[FLG_Z] = alu_flags[FLG_Z];
            flags_d[FLG_S] = alu_flags[FLG_S];
            flags_d[FLG_V] = alu_flags[FLG_V];
            if (op_q == ALU_ADD || op_q == ALU_SUB) flags_d[FLG_C] = alu_flags[FLG_C];
            res_data_d     = alu_out;
            res_err_d      = 1'b0;
          end else begin
            res_data_d     = 8'h00;
            res_err_d      = 1'b1;
          end
          res_valid_d = 1'b1;
          state_d     = ST_DONE;
        end
      end

`ifdef ALU_SEQ_ADC_EN
      ST_EXEC2: begin
        rf_we          = 1'b1;
        flags_d[FLG_C] = c1_q | alu_flags[FLG_C];
        flags_d[FLG_Z] = alu_flags[FLG_Z];
        flags_d[FLG_S] = alu_flags[FLG_S];
        flags_d[FLG_V] = v1_q ^ alu_flags[FLG_V];
        res_data_d     = alu_out;
        res_err_d      = 1'b0;
        res_valid_d    = 1'b1;
        state_d        = ST_DONE;
      end
`endif

      ST_DONE: begin
        if (res_ready) begin
          res_valid_d   = 1'b0;
          instr_ready_d = 1'b1;
          state_d       = ST_IDLE;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        res_valid_d   = 1'b0;
        instr_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      op_q          <= 4'h0;
      rd_q          <= '0;
      alu_in1_q     <= 8'h00;
      alu_in2_q     <= 8'h00;
      alu_op_q      <= 4'h0;
      flags_q       <= 4'h0;
      res_valid_q   <= 1'b0;
      res_data_q    <= 8'h00;
      res_err_q     <= 1'b0;
      instr_ready_q <= 1'b1;
`ifdef ALU_SEQ_ADC_EN
      c1_q          <= 1'b0;
      v1_q          <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      rd_q          <= rd_d;
      alu_in1_q     <= alu_in1_d;
      alu_in2_q     <= alu_in2_d;
      alu_op_q      <= alu_op_d;
      flags_q       <= flags_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_err_q     <= res_err_d;
      instr_ready_q <= instr_ready_d;
`ifdef ALU_SEQ_ADC_EN
      c1_q          <= c1_d;
      v1_q          <= v1_d;
`endif
    end
  end

  assign instr_ready = instr_ready_q;
  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign alu_op      = alu_op_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_flags   = flags_q;
  assign res_err     = res_err_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer with a behavioural ALU stub and reference model.
// Follows ALU_SEQ_ADC_EN the same way the design does.
module tb_alu_sequencer;
   import alu_pkg::*;

   logic       clk;
   logic       rst;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] instr_op;
   logic [1:0] instr_rd;
   logic [1:0] instr_rs1;
   logic [1:0] instr_rs2;
   logic       instr_use_imm;
   logic [7:0] instr_imm;
   logic [7:0] alu_in1;
   logic [7:0] alu_in2;
   logic [3:0] alu_op;
   logic [7:0] alu_out;
   logic [3:0] alu_flags;
   logic       res_valid;
   logic       res_ready;
   logic [7:0] res_data;
   logic [3:0] res_flags;
   logic       res_err;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [7:0] data;
      logic [3:0] flags;
      logic       err;
      int         lat;
      int         acceptCyc;
   } expItem_t;

   expItem_t   expQ[$];
   logic [7:0] refRegs [4];
   logic [3:0] refFlags;

   logic       forcedReady = 1'b1;
   logic       randReadyEn = 1'b0;

   logic       prevValid = 1'b0;
   logic       prevReady = 1'b0;
   logic [7:0] heldData = 8'h00;
   logic [3:0] heldFlags = 4'h0;
   logic       heldErr = 1'b0;
   int         firstCyc = 0;

   logic [3:0] opsList [10] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd11, 4'd12, 4'd7, 4'd5, 4'd15};

   alu_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .instr_op      (instr_op),
      .instr_rd      (instr_rd),
      .instr_rs1     (instr_rs1),
      .instr_rs2     (instr_rs2),
      .instr_use_imm (instr_use_imm),
      .instr_imm     (instr_imm),
      .alu_in1       (alu_in1),
      .alu_in2       (alu_in2),
      .alu_op        (alu_op),
      .alu_out       (alu_out),
      .alu_flags     (alu_flags),
      .res_valid     (res_valid),
      .res_ready     (res_ready),
      .res_data      (res_data),
      .res_flags     (res_flags),
      .res_err       (res_err)
   );

   // Free-running 10ns clock plus a cycle counter used for latency measurement.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the real ALU. Logic ops report a junk carry so that carry
   // retention in the sequencer is actually exercised; unsupported ops return garbage.
   function automatic logic [11:0] aluStub(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [8:0] wide;
      logic [7:0] r;
      logic       c;
      logic       v;
      c = 1'b0;
      v = 1'b0;
      case (op)
         4'd0: begin
            wide = {1'b0, a} + {1'b0, b};
            r = wide[7:0];
            c = wide[8];
            v = (a[7] == b[7]) && (r[7] != a[7]);
         end
         4'd1: begin
            r = a - b;
            c = (a < b);
            v = (a[7] != b[7]) && (r[7] != a[7]);
         end
         4'd2:  begin r = a & b; c = ~a[0]; end
         4'd3:  begin r = a | b; c = ~a[0]; end
         4'd4:  begin r = a ^ b; c = ~a[0]; end
         4'd11: begin r = ~a;    c = ~a[0]; end
         default: begin r = a ^ b ^ 8'hA5; c = 1'b1; v = 1'b1; end
      endcase
      return {c, (r == 8'h00), r[7], v, r};
   endfunction

   always_comb {alu_flags, alu_out} = aluStub(alu_op, alu_in1, alu_in2);

   // Drives res_ready just after each rising edge, either randomly or from a fixed level.
   initial begin
      res_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         res_ready = randReadyEn ? 1'($urandom_range(0, 1)) : forcedReady;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   // Reference model: architectural effect of one instruction, computed with plain
   // integer arithmetic on the register/flag state as it stands at issue time.
   task automatic refExec(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                          input logic [1:0] rs2, input logic useImm, input logic [7:0] imm,
                          output expItem_t e);
      int a, b, sa, sb, full, sfull, cin;
      logic [7:0] r;
      logic c, v, ok;
      a  = int'(refRegs[rs1]);
      b  = useImm ? int'(imm) : int'(refRegs[rs2]);
      sa = (a > 127) ? a - 256 : a;
      sb = (b > 127) ? b - 256 : b;
      c  = refFlags[3];
      v  = 1'b0;
      ok = 1'b1;
      r  = 8'h00;
      e.lat = 1;
      case (op)
         4'd0: begin
            full = a + b; r = 8'(full); c = (full > 255);
            sfull = sa + sb; v = (sfull > 127) || (sfull < -128);
         end
         4'd1: begin
            full = a - b; r = 8'(full); c = (a < b);
            sfull = sa - sb; v = (sfull > 127) || (sfull < -128);
         end
         4'd2:  r = 8'(a & b);
         4'd3:  r = 8'(a | b);
         4'd4:  r = 8'(a ^ b);
         4'd11: r = 8'(255 - a);
`ifdef ALU_SEQ_ADC_EN
         4'd12: begin
            cin = int'(refFlags[3]);
            full = a + b + cin; r = 8'(full); c = (full > 255);
            sfull = sa + sb + cin; v = (sfull > 127) || (sfull < -128);
            e.lat = 2;
         end
`endif
         default: ok = 1'b0;
      endcase
      if (ok) begin
         refRegs[rd] = r;
         refFlags    = {c, (r == 8'h00), r[7], v};
         e.data      = r;
         e.err       = 1'b0;
      end else begin
         e.data      = 8'h00;
         e.err       = 1'b1;
      end
      e.flags = refFlags;
      e.acceptCyc = 0;
   endtask

   // Offers one instruction, waits for the accepting edge and, if tracked,
   // pushes the reference result onto the scoreboard queue.
   task automatic applyStimulus(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                input logic [1:0] rs2, input logic useImm, input logic [7:0] imm,
                                input bit track);
      int waited;
      expItem_t e;
      waited = 0;
      @(negedge clk);
      while (!instr_ready && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!instr_ready) begin
         checks++;
         errors++;
         $display("[TB] FAIL issue: instr_ready got 0, expected 1 within %0d cycles", waited);
         return;
      end
      instr_op      = op;
      instr_rd      = rd;
      instr_rs1     = rs1;
      instr_rs2     = rs2;
      instr_use_imm = useImm;
      instr_imm     = imm;
      instr_valid   = 1'b1;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      if (track) begin
         refExec(op, rd, rs1, rs2, useImm, imm, e);
         e.acceptCyc = cyc;
         expQ.push_back(e);
      end
   endtask

   // Directed spot check with hand-computed constants for the next result.
   task automatic waitCheck(input string name, input logic [7:0] data, input logic [3:0] flags, input logic err);
      int waited;
      waited = 0;
      @(negedge clk);
      while (!res_valid && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      if (!res_valid) begin
         checks++;
         errors++;
         $display("[TB] FAIL %s: res_valid got 0, expected 1 within 10 cycles", name);
         return;
      end
      checkOutput({name, " data"}, 32'(res_data), 32'(data));
      checkOutput({name, " flags"}, 32'(res_flags), 32'(flags));
      checkOutput({name, " err"}, 32'(res_err), 32'(err));
   endtask

   // Monitor: pops the scoreboard on every completed result handshake, and
   // checks that a stalled result holds its value.
   initial begin
      expItem_t e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prevValid = 1'b0;
            prevReady = 1'b0;
         end else begin
            if (res_valid && !prevValid) firstCyc = cyc;
            if (res_valid && prevValid && !prevReady) begin
               checkOutput("stall hold data", 32'(res_data), 32'(heldData));
               checkOutput("stall hold flags", 32'(res_flags), 32'(heldFlags));
               checkOutput("stall hold err", 32'(res_err), 32'(heldErr));
            end
            if (res_valid && res_ready) begin
               if (expQ.size() == 0) begin
                  checks++;
                  errors++;
                  $display("[TB] FAIL unexpected result: got data 0x%0h, expected no result", res_data);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("sb data", 32'(res_data), 32'(e.data));
                  checkOutput("sb flags", 32'(res_flags), 32'(e.flags));
                  checkOutput("sb err", 32'(res_err), 32'(e.err));
                  checkOutput("sb latency", 32'(firstCyc - e.acceptCyc), 32'(e.lat));
               end
            end
            heldData  = res_data;
            heldFlags = res_flags;
            heldErr   = res_err;
            prevValid = res_valid;
            prevReady = res_ready;
         end
      end
   end

   // Main sequence: reset, directed cases, mid-instruction reset, then random traffic.
   initial begin
      int waited;
      rst           = 1'b1;
      instr_valid   = 1'b0;
      instr_op      = 4'h0;
      instr_rd      = 2'd0;
      instr_rs1     = 2'd0;
      instr_rs2     = 2'd0;
      instr_use_imm = 1'b0;
      instr_imm     = 8'h00;
      for (int i = 0; i < 4; i++) refRegs[i] = 8'h00;
      refFlags = 4'h0;

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      $display("[TB] reset released");
      checkOutput("reset instr_ready", 32'(instr_ready), 32'd1);
      checkOutput("reset res_valid", 32'(res_valid), 32'd0);
      checkOutput("reset res_data", 32'(res_data), 32'd0);
      checkOutput("reset res_flags", 32'(res_flags), 32'd0);
      checkOutput("reset res_err", 32'(res_err), 32'd0);
      checkOutput("reset alu_in1", 32'(alu_in1), 32'd0);
      checkOutput("reset alu_in2", 32'(alu_in2), 32'd0);
      checkOutput("reset alu_op", 32'(alu_op), 32'd0);

      // 0x7F + 1 -> 0x80 with sign and overflow set
      applyStimulus(ALU_OR, 2'd1, 2'd0, 2'd0, 1'b1, 8'h7F, 1'b1);
      applyStimulus(ALU_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 1'b1);
      waitCheck("add 7F+1", 8'h80, 4'b0011, 1'b0);

      // SUB x-x gives zero, then 0-1 borrows
      applyStimulus(ALU_OR, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 1'b1);
      applyStimulus(ALU_SUB, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00, 1'b1);
      waitCheck("sub 5-5", 8'h00, 4'b0100, 1'b0);
      applyStimulus(ALU_SUB, 2'd3, 2'd3, 2'd0, 1'b1, 8'h01, 1'b1);
      waitCheck("sub 0-1", 8'hFF, 4'b1010, 1'b0);

      // Carry from ADD survives a following logic op
      applyStimulus(ALU_OR, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, 1'b1);
      applyStimulus(ALU_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'h01, 1'b1);
      waitCheck("add FF+1", 8'h00, 4'b1100, 1'b0);
      applyStimulus(ALU_OR, 2'd1, 2'd0, 2'd0, 1'b1, 8'h0F, 1'b1);
      applyStimulus(ALU_AND, 2'd3, 2'd1, 2'd0, 1'b1, 8'hF0, 1'b1);
      waitCheck("and carry kept", 8'h00, 4'b1100, 1'b0);

      // Unsupported op with a 5-cycle downstream stall
      forcedReady = 1'b0;
      applyStimulus(4'd7, 2'd1, 2'd1, 2'd2, 1'b0, 8'h00, 1'b1);
      waitCheck("op7", 8'h00, 4'b1100, 1'b1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("op7 stall res_valid", 32'(res_valid), 32'd1);
         checkOutput("op7 stall instr_ready", 32'(instr_ready), 32'd0);
         checkOutput("op7 stall res_data", 32'(res_data), 32'd0);
         checkOutput("op7 stall res_err", 32'(res_err), 32'd1);
      end
      forcedReady = 1'b1;
      applyStimulus(ALU_OR, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00, 1'b1);
      waitCheck("rd kept after op7", 8'h0F, 4'b1000, 1'b0);

      // ADC 0xFF + 0x00 with carry in set
      applyStimulus(ALU_OR, 2'd1, 2'd0, 2'd0, 1'b1, 8'hFF, 1'b1);
      applyStimulus(ALU_ADC, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00, 1'b1);
`ifdef ALU_SEQ_ADC_EN
      waitCheck("adc FF+0+1", 8'h00, 4'b1100, 1'b0);
`else
      waitCheck("adc unsupported", 8'h00, 4'b1010, 1'b1);
`endif

      // Reset during the EXEC cycle of a write to R0
      applyStimulus(ALU_ADD, 2'd0, 2'd1, 2'd0, 1'b1, 8'h33, 1'b0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkOutput("in-reset res_valid", 32'(res_valid), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) refRegs[i] = 8'h00;
      refFlags = 4'h0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("post-reset res_valid", 32'(res_valid), 32'd0);
      end
      checkOutput("post-reset instr_ready", 32'(instr_ready), 32'd1);
      applyStimulus(ALU_OR, 2'd2, 2'd0, 2'd0, 1'b1, 8'h00, 1'b1);
      waitCheck("R0 after dropped write", 8'h00, 4'b0100, 1'b0);

      // Random traffic with random downstream back-pressure
      $display("[TB] starting random phase");
      randReadyEn = 1'b1;
      for (int i = 0; i < 80; i++) begin
         applyStimulus(opsList[$urandom_range(0, 9)], 2'($urandom_range(0, 3)),
                       2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
      end
      randReadyEn = 1'b0;
      forcedReady = 1'b1;

      waited = 0;
      while (expQ.size() != 0 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      checkOutput("pending results drained", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
